// File: rtl/aes_req_arbiter_if.sv
// Requester and core side signal bundle for the shared AES arbiter.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
interface aes_req_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int GW = $clog2(NREQ);

  logic                   key_stall;
  logic [NREQ-1:0]        req_valid;
  logic [128*NREQ-1:0]    req_pt;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        resp_valid;
  logic [NREQ-1:0]        resp_ready;
  logic [127:0]           resp_ct;
  logic                   resp_err;
  logic [GW-1:0]          resp_idx;
  logic                   busy;
  logic                   aes_load;
  logic [127:0]           aes_pt;
  logic [127:0]           aes_ct;
  logic                   aes_valid;

  // Arbiter side
  modport slave (
    input  key_stall, req_valid, req_pt, resp_ready, aes_ct, aes_valid,
    output req_ready, resp_valid, resp_ct, resp_err, resp_idx, busy, aes_load, aes_pt
  );

  // Requesters plus core side
  modport master (
    output key_stall, req_valid, req_pt, resp_ready, aes_ct, aes_valid,
    input  req_ready, resp_valid, resp_ct, resp_err, resp_idx, busy, aes_load, aes_pt
  );
endinterface

// File: rtl/aes_req_arbiter.sv
// Round-robin sharing of one AES core among NREQ requesters, one block in flight.
// Latency: 1 IDLE cycle + core latency (or TIMEOUT on error) + 1 RESP cycle per block.
// Backpressure: no grant while key_stall or busy; response held until resp_ready of the served requester.
module aes_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst_n,
  aes_req_arbiter_if.slave bus
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [GW-1:0]   r_ptr;
  logic [GW-1:0]   r_resp_idx;
  logic [CW-1:0]   r_cnt;
  logic [127:0]    r_aes_pt;
  logic [127:0]    r_resp_ct;
  logic            r_aes_load;
  logic            r_resp_err;

  logic [NREQ-1:0] w_mask_hi;
  logic [NREQ-1:0] w_req_hi;
  logic [GW-1:0]   w_gnt_idx;
  logic            w_grant;
  logic            w_timeout;
  logic            w_resp_hs;

  assign w_grant   = (r_state == S_IDLE) && !bus.key_stall && (|bus.req_valid);
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
  assign w_resp_hs = (r_state == S_RESP) && bus.resp_ready[r_resp_idx];

  // Round-robin pick: lowest valid index above the last served one, else lowest valid overall
  always_comb begin
    w_mask_hi = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_mask_hi[i] = (i > int'(r_ptr));
    end
    w_req_hi  = bus.req_valid & w_mask_hi;
    w_gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) w_gnt_idx = GW'(i);
    end
    if (|w_req_hi) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (w_req_hi[i]) w_gnt_idx = GW'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: grant -> wait for core (valid or timeout) -> hold response until accepted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.aes_valid || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  if (w_resp_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: one-hot accept in IDLE, one-hot response valid in RESP
  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.busy       = (r_state != S_IDLE);
    if (w_grant) bus.req_ready[w_gnt_idx] = 1'b1;
    if (r_state == S_RESP) bus.resp_valid[r_resp_idx] = 1'b1;
  end

  // Datapath: latch plaintext on grant, capture result or error in WAIT, advance pointer on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aes_pt   <= '0;
      r_aes_load <= 1'b0;
      r_resp_ct  <= '0;
      r_resp_err <= 1'b0;
      r_resp_idx <= '0;
      r_ptr      <= GW'(NREQ - 1);
      r_cnt      <= '0;
    end else begin
      r_aes_load <= w_grant;
      if (w_grant) begin
        r_aes_pt   <= bus.req_pt[128*w_gnt_idx +: 128];
        r_resp_idx <= w_gnt_idx;
        r_cnt      <= '0;
      end
      if (r_state == S_WAIT) begin
        if (bus.aes_valid) begin
          r_resp_ct  <= bus.aes_ct;
          r_resp_err <= 1'b0;
        end else if (w_timeout) begin
          r_resp_ct  <= '0;
          r_resp_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (w_resp_hs) r_ptr <= r_resp_idx;
    end
  end

  assign bus.aes_load = r_aes_load;
  assign bus.aes_pt   = r_aes_pt;
  assign bus.resp_ct  = r_resp_ct;
  assign bus.resp_err = r_resp_err;
  assign bus.resp_idx = r_resp_idx;
endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter: core stub, scoreboard monitor, directed scenarios and random traffic.
`timescale 1ns/1ps
module tb_aes_req_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_req_arbiter_if #(.NREQ(NREQ)) bus ();
  aes_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int           idx;
    logic [127:0] ct;
    logic         err;
    int           lat;
  } exp_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_load = 0;
  int m_ptr = NREQ - 1;
  bit m_busy = 0;
  int grant_cyc = -100;
  logic [127:0] grant_pt;
  exp_t sb[$];
  int grant_log[$];
  int force_lat = -1;
  int stub_lat = 0;
  int stub_cnt = 0;
  logic [127:0] stub_pt;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expire(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Stand-in for the AES core: known answer for the FIPS vector, a scramble otherwise
  function automatic logic [127:0] core_f(input logic [127:0] pt);
    if (pt == FIPS_PT) return FIPS_CT;
    return {pt[62:0], pt[127:63]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // 0 = core never answers; values above TIMEOUT answer too late
  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r != 0) return $urandom_range(1, 6);
    r = $urandom_range(0, 4);
    if (r == 0) return 0;
    return TIMEOUT - 2 + r;
  endfunction

  // Core stub: raises aes_valid in the stub_lat-th cycle counting the load cycle as the first
  initial begin
    bus.aes_valid = 1'b0;
    bus.aes_ct    = '0;
    forever begin
      @(negedge clk);
      bus.aes_valid = 1'b0;
      bus.aes_ct    = rand128();
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          bus.aes_valid = 1'b1;
          bus.aes_ct    = core_f(stub_pt);
        end
      end
      if (bus.aes_load) begin
        stub_pt  = bus.aes_pt;
        stub_cnt = 0;
        if (stub_lat == 1) begin
          bus.aes_valid = 1'b1;
          bus.aes_ct    = core_f(stub_pt);
        end else if (stub_lat > 1) begin
          stub_cnt = stub_lat - 1;
        end
      end
    end
  end

  // Monitor and reference model: round-robin over valid requests, one block at a time
  initial begin
    forever begin
      int g;
      int lat;
      logic [NREQ-1:0] exp_rdy;
      logic [NREQ-1:0] exp_rv;
      exp_t e;
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check("rst aes_load", bus.aes_load, 0);
        check("rst aes_pt", bus.aes_pt, 0);
        check("rst resp_valid", bus.resp_valid, 0);
        check("rst resp_ct", bus.resp_ct, 0);
        check("rst resp_err", bus.resp_err, 0);
        check("rst resp_idx", bus.resp_idx, 0);
        check("rst busy", bus.busy, 0);
        sb.delete();
        m_busy    = 0;
        m_ptr     = NREQ - 1;
        grant_cyc = -100;
      end else begin
        if (bus.aes_load) n_load++;
        check("busy", bus.busy, m_busy);
        check("aes_load", bus.aes_load, (cyc == grant_cyc + 1));
        if (cyc == grant_cyc + 1) check("aes_pt", bus.aes_pt, grant_pt);
        g = -1;
        exp_rdy = '0;
        if (!m_busy && !bus.key_stall) begin
          for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (g < 0 && bus.req_valid[j]) g = j;
          end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", bus.req_ready, exp_rdy);
        if (!m_busy || sb.size() == 0) begin
          check("resp_valid idle", bus.resp_valid, 0);
        end else begin
          e = sb[0];
          exp_rv = '0;
          if (cyc >= grant_cyc + 1 + e.lat) exp_rv[e.idx] = 1'b1;
          check("resp_valid", bus.resp_valid, exp_rv);
          if (|bus.resp_valid) begin
            check("resp_idx", bus.resp_idx, e.idx);
            check("resp_ct", bus.resp_ct, e.ct);
            check("resp_err", bus.resp_err, e.err);
          end
          if (exp_rv != 0 && bus.resp_ready[e.idx]) begin
            void'(sb.pop_front());
            m_ptr  = e.idx;
            m_busy = 0;
          end
        end
        if (g >= 0) begin
          lat      = (force_lat >= 0) ? force_lat : pick_lat();
          stub_lat = lat;
          e.idx    = g;
          e.err    = (lat == 0 || lat > TIMEOUT);
          e.ct     = e.err ? 128'h0 : core_f(bus.req_pt[128*g +: 128]);
          e.lat    = e.err ? TIMEOUT : lat;
          sb.push_back(e);
          grant_pt  = bus.req_pt[128*g +: 128];
          grant_cyc = cyc;
          m_busy    = 1;
          grant_log.push_back(g);
        end
      end
    end
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic req_until_ack(input int i, input logic [127:0] pt);
    int n;
    @(posedge clk);
    #1;
    bus.req_pt[128*i +: 128] = pt;
    bus.req_valid[i] = 1'b1;
    for (n = 0; n < 300; n++) begin
      sample();
      if (bus.req_ready[i]) break;
      @(posedge clk);
      #1;
    end
    if (n >= 300) expire("req ack");
    @(posedge clk);
    #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    int n;
    for (n = 0; n < 300; n++) begin
      sample();
      if (|bus.resp_valid) break;
    end
    if (n >= 300) expire(name);
  endtask

  task automatic drain(input int budget);
    logic [NREQ-1:0] acc;
    int n;
    for (n = 0; n < budget; n++) begin
      sample();
      acc = bus.req_ready;
      if (bus.req_valid == 0 && !m_busy) break;
      @(posedge clk);
      #1;
      bus.req_valid = bus.req_valid & ~acc;
    end
    if (n >= budget) expire("drain");
  endtask

  task automatic rand_cycle();
    logic [NREQ-1:0] acc;
    sample();
    acc = bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        bus.req_valid[i] = ($urandom_range(0, 3) == 0);
        bus.req_pt[128*i +: 128] = rand128();
      end else if (bus.req_valid[i]) begin
        if ($urandom_range(0, 19) == 0) bus.req_valid[i] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.req_valid[i] = 1'b1;
        bus.req_pt[128*i +: 128] = rand128();
      end
      bus.resp_ready[i] = ($urandom_range(0, 9) < 7);
    end
    bus.key_stall = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n0;
    int hits;
    logic [127:0] ct_snap;
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 0, 1};
    bus.key_stall  = 1'b0;
    bus.req_valid  = '0;
    bus.req_pt     = '0;
    bus.resp_ready = '0;
    do_reset();

    // Known-answer block through requester 2
    force_lat = 3;
    bus.resp_ready = '1;
    req_until_ack(2, FIPS_PT);
    wait_resp("t1 resp");
    check("t1 resp_valid", bus.resp_valid, 4'b0100);
    check("t1 resp_idx", bus.resp_idx, 2);
    check("t1 resp_ct", bus.resp_ct, FIPS_CT);
    check("t1 resp_err", bus.resp_err, 0);
    drain(100);

    // All requesters held valid after reset: rotation 0,1,2,3,0,1
    do_reset();
    force_lat = 2;
    grant_log.delete();
    n0 = n_load;
    bus.resp_ready = '1;
    for (int i = 0; i < NREQ; i++) bus.req_pt[128*i +: 128] = rand128();
    bus.req_valid = '1;
    for (k = 0; k < 200; k++) begin
      sample();
      if (grant_log.size() >= 6) break;
    end
    if (k >= 200) expire("t2 grants");
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    drain(100);
    check("t2 grant count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) check("t2 grant order", grant_log[i], exp_order[i]);
    check("t2 load count", n_load - n0, 6);

    // key_stall blocks grants; release grants in the same cycle
    @(posedge clk);
    #1;
    bus.key_stall = 1'b1;
    bus.req_pt[128*1 +: 128] = rand128();
    bus.req_valid[1] = 1'b1;
    hits = 0;
    n0 = n_load;
    repeat (20) begin
      sample();
      if (bus.req_ready != 0) hits++;
    end
    check("t3 stalled ready", hits, 0);
    check("t3 stalled load", n_load - n0, 0);
    @(posedge clk);
    #1;
    bus.key_stall = 1'b0;
    sample();
    check("t3 release ready", bus.req_ready, 4'b0010);
    drain(100);

    // Core never answers: error response TIMEOUT cycles after load
    force_lat = 0;
    req_until_ack(0, rand128());
    sample();
    check("t4 load", bus.aes_load, 1);
    for (k = 0; k < 200; k++) begin
      sample();
      if (|bus.resp_valid) break;
    end
    check("t4 cycles to resp", k + 1, TIMEOUT);
    check("t4 resp_err", bus.resp_err, 1);
    check("t4 resp_ct", bus.resp_ct, 0);
    drain(100);
    // Core answers after the timeout: late valid must be dropped
    force_lat = TIMEOUT + 2;
    req_until_ack(1, rand128());
    wait_resp("t4 late resp");
    check("t4 late err", bus.resp_err, 1);
    drain(100);
    repeat (5) sample();

    // Response held while resp_ready is low, with other requests waiting
    force_lat = 2;
    bus.resp_ready = '0;
    req_until_ack(3, rand128());
    bus.req_pt[0 +: 128]   = rand128();
    bus.req_pt[128 +: 128] = rand128();
    bus.req_valid[1:0] = 2'b11;
    wait_resp("t5 resp");
    ct_snap = bus.resp_ct;
    hits = 0;
    n0 = n_load;
    repeat (10) begin
      sample();
      if (bus.req_ready != 0) hits++;
      if (bus.resp_ct !== ct_snap || bus.resp_valid !== 4'b1000) hits++;
    end
    check("t5 held", hits, 0);
    check("t5 no load", n_load - n0, 0);
    @(posedge clk);
    #1;
    bus.resp_ready = '1;
    sample();
    sample();
    check("t5 next grant", bus.req_ready, 4'b0001);
    drain(100);

    // Reset in the middle of a block; the core's late answer must not show up
    do_reset();
    force_lat = 20;
    bus.resp_ready = '1;
    req_until_ack(3, rand128());
    repeat (4) @(posedge clk);
    do_reset();
    hits = 0;
    repeat (25) begin
      sample();
      if (bus.busy || bus.resp_valid != 0) hits++;
    end
    check("t6 idle after reset", hits, 0);
    @(posedge clk);
    #1;
    force_lat = -1;
    bus.req_pt[0 +: 128]   = rand128();
    bus.req_pt[384 +: 128] = rand128();
    bus.req_valid = 4'b1001;
    sample();
    check("t6 first grant", bus.req_ready, 4'b0001);
    drain(100);

    // Random traffic against the scoreboard
    repeat (1500) rand_cycle();
    @(posedge clk);
    #1;
    bus.key_stall  = 1'b0;
    bus.resp_ready = '1;
    drain(3000);
    check("final scoreboard empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
